// File: rtl/aoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aoc_pkg
//  Description : ASCII constants shared by the string filter and reporter,
//                plus the reporter state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package aoc_pkg;

    localparam logic [7:0] LF_CHAR   = 8'h0A;
    localparam logic [7:0] NULL_CHAR = 8'h00;
    localparam logic [7:0] ZERO_CHAR = 8'h30;

    typedef enum logic [2:0] {
        ST_COUNT   = 3'd0,
        ST_CONVERT = 3'd1,
        ST_SEEK    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } reporter_state_t;

endpackage
`default_nettype wire

// File: rtl/binary_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_bcd
//  Description : Iterative double-dabble converter, one bit per cycle, MSB
//                first; result valid BINARY_WIDTH cycles after start.
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd #(
    parameter int BINARY_WIDTH = 16,
    parameter int DIGITS       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BINARY_WIDTH-1:0] binary,
    output logic                    busy,
    output logic [DIGITS*4-1:0]     bcd
);

    localparam int C_CNT_W = $clog2(BINARY_WIDTH + 1);

    logic [BINARY_WIDTH-1:0] r_shift;
    logic [C_CNT_W-1:0]      r_remaining;
    logic [DIGITS*4-1:0]     r_bcd;
    logic [DIGITS*4-1:0]     w_adjusted;

    // Add 3 to every digit >= 5 before the shift so it carries correctly
    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_adjust
            assign w_adjusted[d*4 +: 4] = (r_bcd[d*4 +: 4] >= 4'd5) ?
                                          r_bcd[d*4 +: 4] + 4'd3 : r_bcd[d*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_remaining <= '0;
            r_bcd       <= '0;
        end else if (start) begin
            r_shift     <= binary;
            r_remaining <= C_CNT_W'(BINARY_WIDTH);
            r_bcd       <= '0;
        end else if (r_remaining != '0) begin
            r_bcd       <= (w_adjusted << 1) |
                           {{(DIGITS*4-1){1'b0}}, r_shift[BINARY_WIDTH-1]};
            r_shift     <= r_shift << 1;
            r_remaining <= r_remaining - C_CNT_W'(1);
        end
    end

    assign busy = (r_remaining != '0);
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/nice_count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : nice_count_reporter
//  Description : Counts nice-line pulses until end of file, then streams the
//                count as ASCII decimal plus LF over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module nice_count_reporter
    import aoc_pkg::*;
#(
    parameter int RESULT_WIDTH        = 16,
    parameter int OUTBOUND_DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           end_of_file,
    input  logic                           string_is_nice,
    output logic                           outbound_valid,
    input  logic                           outbound_ready,
    output logic [OUTBOUND_DATA_WIDTH-1:0] outbound_data,
    output logic [RESULT_WIDTH-1:0]        result,
    output logic                           result_valid,
    output logic                           overflow,
    output logic                           done
);

    localparam int DIGITS  = ((RESULT_WIDTH * 1233) >> 12) + 1;
    localparam int C_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int C_CYC_W = $clog2(RESULT_WIDTH + 1);

    reporter_state_t         r_state;
    logic [RESULT_WIDTH-1:0] r_count;
    logic [RESULT_WIDTH-1:0] w_count_next;
    logic                    w_saturate;
    logic [C_CYC_W-1:0]      r_cycles;
    logic [C_IDX_W-1:0]      r_idx;
    logic                    r_on_lf;
    logic [C_IDX_W-1:0]      w_start_idx;
    logic [C_IDX_W-1:0]      w_next_idx;
    logic [3:0]              w_next_digit;
    logic [DIGITS*4-1:0]     w_bcd;
    logic                    w_conv_start;
    logic                    w_conv_busy;
    logic [7:0]              w_next_char;

    assign w_saturate   = string_is_nice && (&r_count);
    assign w_count_next = (string_is_nice && !(&r_count)) ?
                          r_count + RESULT_WIDTH'(1) : r_count;
    // Converter is loaded on the same edge the FSM leaves COUNT
    assign w_conv_start = (r_state == ST_COUNT) && end_of_file;

    binary_to_bcd #(
        .BINARY_WIDTH (RESULT_WIDTH),
        .DIGITS       (DIGITS)
    ) u_binary_to_bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (w_conv_start),
        .binary (w_count_next),
        .busy   (w_conv_busy),
        .bcd    (w_bcd)
    );

    // Highest nonzero digit starts the stream; all-zero falls back to digit 0
    always_comb begin
        w_start_idx = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_bcd[d*4 +: 4] != 4'd0) w_start_idx = C_IDX_W'(d);
        end
        w_next_idx   = (r_state == ST_SEEK) ? w_start_idx : r_idx - C_IDX_W'(1);
        w_next_digit = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (C_IDX_W'(d) == w_next_idx) w_next_digit = w_bcd[d*4 +: 4];
        end
        w_next_char = ZERO_CHAR + {4'b0000, w_next_digit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_COUNT;
            r_count        <= '0;
            r_cycles       <= '0;
            r_idx          <= '0;
            r_on_lf        <= 1'b0;
            outbound_valid <= 1'b0;
            outbound_data  <= '0;
            result         <= '0;
            result_valid   <= 1'b0;
            overflow       <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (r_state)
                ST_COUNT: begin
                    r_count <= w_count_next;
                    if (w_saturate) overflow <= 1'b1;
                    if (end_of_file) begin
                        result       <= w_count_next;
                        result_valid <= 1'b1;
                        r_cycles     <= '0;
                        r_state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_cycles <= r_cycles + C_CYC_W'(1);
                    if ((r_cycles == C_CYC_W'(RESULT_WIDTH - 1)) || !w_conv_busy)
                        r_state <= ST_SEEK;
                end
                ST_SEEK: begin
                    r_idx          <= w_start_idx;
                    r_on_lf        <= 1'b0;
                    outbound_valid <= 1'b1;
                    outbound_data  <= OUTBOUND_DATA_WIDTH'(w_next_char);
                    r_state        <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (outbound_valid && outbound_ready) begin
                        if (r_on_lf) begin
                            outbound_valid <= 1'b0;
                            outbound_data  <= OUTBOUND_DATA_WIDTH'(NULL_CHAR);
                            done           <= 1'b1;
                            r_state        <= ST_DONE;
                        end else if (r_idx == '0) begin
                            outbound_data <= OUTBOUND_DATA_WIDTH'(LF_CHAR);
                            r_on_lf       <= 1'b1;
                        end else begin
                            r_idx         <= w_next_idx;
                            outbound_data <= OUTBOUND_DATA_WIDTH'(w_next_char);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_COUNT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nice_count_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nice_count_reporter
//  Description : Self-checking bench; drives a 16-bit and an 8-bit reporter
//                with shared stimulus and compares both against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nice_count_reporter;

    logic        clk = 1'b0;
    logic        reset;
    logic        end_of_file;
    logic        string_is_nice;
    logic        outbound_ready;

    logic        v16, v8;
    logic [7:0]  d16, d8;
    logic [15:0] r16;
    logic [7:0]  r8;
    logic        rv16, rv8, ov16, ov8, dn16, dn8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nice_count_reporter #(.RESULT_WIDTH(16), .OUTBOUND_DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .end_of_file    (end_of_file),
        .string_is_nice (string_is_nice),
        .outbound_valid (v16),
        .outbound_ready (outbound_ready),
        .outbound_data  (d16),
        .result         (r16),
        .result_valid   (rv16),
        .overflow       (ov16),
        .done           (dn16)
    );

    nice_count_reporter #(.RESULT_WIDTH(8), .OUTBOUND_DATA_WIDTH(8)) dut_w8 (
        .clk            (clk),
        .reset          (reset),
        .end_of_file    (end_of_file),
        .string_is_nice (string_is_nice),
        .outbound_valid (v8),
        .outbound_ready (outbound_ready),
        .outbound_data  (d8),
        .result         (r8),
        .result_valid   (rv8),
        .overflow       (ov8),
        .done           (dn8)
    );

    task automatic apply_reset;
        reset          = 1'b1;
        string_is_nice = 1'b0;
        end_of_file    = 1'b0;
        outbound_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Pulses n_pre lines, raises end_of_file (optionally with a coincident
    // pulse), adds n_post ignored pulses, then collects and scores the stream.
    task automatic run_stream(input string tag, input int n_pre, input bit coincide,
                              input int n_post, input int rmode, input bit gaps);
        int n, c16, c8, first16, first8, k;
        bit o16, o8, pv16, pv8, pr, lf16, lf8, fin16, fin8;
        logic [7:0] pd16, pd8;
        logic [7:0] exp16[$], exp8[$], got16[$], got8[$];
        string s;

        n   = n_pre + int'(coincide);
        c16 = (n > 65535) ? 65535 : n;
        o16 = (n > 65535);
        c8  = (n > 255) ? 255 : n;
        o8  = (n > 255);
        s = $sformatf("%0d", c16);
        for (int i = 0; i < s.len(); i++) exp16.push_back(s[i]);
        exp16.push_back(8'h0A);
        s = $sformatf("%0d", c8);
        for (int i = 0; i < s.len(); i++) exp8.push_back(s[i]);
        exp8.push_back(8'h0A);

        for (int i = 0; i < n_pre; i++) begin
            string_is_nice = 1'b1;
            @(negedge clk);
            string_is_nice = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        checks++;
        if (rv16 !== 1'b0 || rv8 !== 1'b0) begin
            errors++;
            $display("FAIL %s result_valid_early: got %b/%b required 0/0", tag, rv16, rv8);
        end

        string_is_nice = coincide;
        end_of_file    = 1'b1;
        @(negedge clk);

        first16 = 0; first8 = 0;
        pv16 = 0; pv8 = 0; pr = 0; pd16 = '0; pd8 = '0;
        lf16 = 0; lf8 = 0; fin16 = 0; fin8 = 0;
        for (k = 1; k <= 400 && !(fin16 && fin8); k++) begin
            if (k == 1) begin
                checks++;
                if (rv16 !== 1'b1 || r16 !== 16'(c16) || ov16 !== o16) begin
                    errors++;
                    $display("FAIL %s result16: got v=%b r=%0d ov=%b required v=1 r=%0d ov=%b",
                             tag, rv16, r16, ov16, c16, o16);
                end
                checks++;
                if (rv8 !== 1'b1 || r8 !== 8'(c8) || ov8 !== o8) begin
                    errors++;
                    $display("FAIL %s result8: got v=%b r=%0d ov=%b required v=1 r=%0d ov=%b",
                             tag, rv8, r8, ov8, c8, o8);
                end
            end
            string_is_nice = (k <= 2 * n_post) && (k % 2 == 1);

            if (!fin16) begin
                checks++;
                if (lf16) begin
                    if (dn16 !== 1'b1 || v16 !== 1'b0 || d16 !== 8'h00) begin
                        errors++;
                        $display("FAIL %s done16: got done=%b v=%b d=%h required 1/0/00", tag, dn16, v16, d16);
                    end
                    fin16 = 1;
                end else begin
                    if (dn16 !== 1'b0 || (!v16 && d16 !== 8'h00) ||
                        (pv16 && !pr && (v16 !== 1'b1 || d16 !== pd16))) begin
                        errors++;
                        $display("FAIL %s stream16 k=%0d: got done=%b v=%b d=%h required done=0, d=00 when idle, held %h when stalled",
                                 tag, k, dn16, v16, d16, pd16);
                    end
                    if (v16 === 1'b1 && first16 == 0) first16 = k;
                end
            end
            if (!fin8) begin
                checks++;
                if (lf8) begin
                    if (dn8 !== 1'b1 || v8 !== 1'b0 || d8 !== 8'h00) begin
                        errors++;
                        $display("FAIL %s done8: got done=%b v=%b d=%h required 1/0/00", tag, dn8, v8, d8);
                    end
                    fin8 = 1;
                end else begin
                    if (dn8 !== 1'b0 || (!v8 && d8 !== 8'h00) ||
                        (pv8 && !pr && (v8 !== 1'b1 || d8 !== pd8))) begin
                        errors++;
                        $display("FAIL %s stream8 k=%0d: got done=%b v=%b d=%h required done=0, d=00 when idle, held %h when stalled",
                                 tag, k, dn8, v8, d8, pd8);
                    end
                    if (v8 === 1'b1 && first8 == 0) first8 = k;
                end
            end

            case (rmode)
                0:       outbound_ready = 1'b1;
                1:       outbound_ready = (k % 2 == 1);
                default: outbound_ready = 1'($urandom_range(0, 1));
            endcase
            if (!fin16 && !lf16 && v16 === 1'b1 && outbound_ready && got16.size() < 12) begin
                got16.push_back(d16);
                if (d16 == 8'h0A) lf16 = 1;
            end
            if (!fin8 && !lf8 && v8 === 1'b1 && outbound_ready && got8.size() < 12) begin
                got8.push_back(d8);
                if (d8 == 8'h0A) lf8 = 1;
            end
            pv16 = (v16 === 1'b1); pd16 = d16;
            pv8  = (v8 === 1'b1);  pd8  = d8;
            pr   = outbound_ready;
            @(negedge clk);
        end
        outbound_ready = 1'b0;
        string_is_nice = 1'b0;

        checks++;
        if (!(fin16 && fin8)) begin
            errors++;
            $display("FAIL %s timeout: got done16=%b done8=%b required both 1 within 400 cycles", tag, fin16, fin8);
        end
        checks++;
        if (first16 != 18 || first8 != 10) begin
            errors++;
            $display("FAIL %s latency: got %0d/%0d required 18/10", tag, first16, first8);
        end
        checks++;
        if (got16.size() != exp16.size() || got8.size() != exp8.size()) begin
            errors++;
            $display("FAIL %s byte_count: got %0d/%0d required %0d/%0d",
                     tag, got16.size(), got8.size(), exp16.size(), exp8.size());
        end
        for (int i = 0; i < exp16.size(); i++) begin
            checks++;
            if (i >= got16.size() || got16[i] !== exp16[i]) begin
                errors++;
                $display("FAIL %s byte16[%0d]: got %h required %h", tag, i,
                         (i < got16.size()) ? got16[i] : 8'hxx, exp16[i]);
            end
        end
        for (int i = 0; i < exp8.size(); i++) begin
            checks++;
            if (i >= got8.size() || got8[i] !== exp8[i]) begin
                errors++;
                $display("FAIL %s byte8[%0d]: got %h required %h", tag, i,
                         (i < got8.size()) ? got8[i] : 8'hxx, exp8[i]);
            end
        end
    endtask

    task automatic test_reset;
        apply_reset;
        checks++;
        if ({v16, d16, r16, rv16, ov16, dn16} !== '0 || {v8, d8, r8, rv8, ov8, dn8} !== '0) begin
            errors++;
            $display("FAIL reset_state: got w16=%h w8=%h required 0",
                     {v16, d16, r16, rv16, ov16, dn16}, {v8, d8, r8, rv8, ov8, dn8});
        end
    endtask

    task automatic test_basic;
        apply_reset;
        run_stream("basic", 3, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_zero;
        apply_reset;
        run_stream("zero", 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_back_pressure;
        apply_reset;
        run_stream("back_pressure", 258, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_saturation;
        apply_reset;
        run_stream("saturation", 300, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_boundary;
        apply_reset;
        run_stream("boundary", 0, 1'b1, 4, 0, 1'b0);
    endtask

    task automatic test_reset_mid_stream;
        int i;
        apply_reset;
        string_is_nice = 1'b1;
        repeat (258) @(negedge clk);
        string_is_nice = 1'b0;
        end_of_file    = 1'b1;
        outbound_ready = 1'b1;
        for (i = 0; i < 100 && v16 !== 1'b1; i++) @(negedge clk);
        checks++;
        if (v16 !== 1'b1 || d16 !== 8'h32) begin
            errors++;
            $display("FAIL midreset_first_byte: got v=%b d=%h required 1/32", v16, d16);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({v16, d16, r16, rv16, ov16, dn16} !== '0 || {v8, d8, r8, rv8, ov8, dn8} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got w16=%h w8=%h required 0",
                     {v16, d16, r16, rv16, ov16, dn16}, {v8, d8, r8, rv8, ov8, dn8});
        end
        @(negedge clk);
        end_of_file    = 1'b0;
        outbound_ready = 1'b0;
        reset          = 1'b0;
        @(negedge clk);
        checks++;
        if (v16 !== 1'b0 || rv16 !== 1'b0 || v8 !== 1'b0 || rv8 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_partial: got v=%b/%b rv=%b/%b required 0", v16, v8, rv16, rv8);
        end
        run_stream("after_reset", 7, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            apply_reset;
            run_stream($sformatf("random%0d", r), $urandom_range(0, 400),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 2, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        end_of_file    = 1'b0;
        string_is_nice = 1'b0;
        outbound_ready = 1'b0;
        test_reset;
        test_basic;
        test_zero;
        test_back_pressure;
        test_saturation;
        test_boundary;
        test_reset_mid_stream;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
